// File: rtl/shift_cmd_sequencer.sv
// shift_cmd_sequencer
//   Queues shift commands, issues them one at a time to an external
//   combinational shifter through registered op/operand outputs, and returns
//   each result downstream over a valid/ready handshake in command order.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready  upstream command handshake
//   cmd_op, cmd_data     command op code and operand
//   sh_type, sh_num      registered op/operand driving the shifter
//   sh_out               shifter result (combinational from sh_type/sh_num)
//   rsp_valid/rsp_ready  downstream result handshake
//   rsp_data, rsp_op     result and the op that produced it
//   rsp_err              op code was unsupported (110/111); rsp_data is 0
//   level                command FIFO occupancy
module shift_cmd_sequencer #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [OP_W-1:0]          cmd_op,
  input  logic [DATA_W-1:0]        cmd_data,
  output logic [OP_W-1:0]          sh_type,
  output logic [DATA_W-1:0]        sh_num,
  input  logic [DATA_W-1:0]        sh_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [OP_W-1:0]          rsp_op,
  output logic                     rsp_err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = OP_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t              state;
  logic [EW-1:0]       mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                push;
  logic                pop;
  logic [OP_W-1:0]     head_op;
  logic [DATA_W-1:0]   head_data;
  logic [OP_W-1:0]     op_q;
  logic                op_unsup;

  // Full/not-full comes from the occupancy register only, so a pop in the
  // same cycle never opens a slot for a push.
  assign cmd_ready = (level != LW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;

  assign head_op   = mem[rd_ptr][EW-1:DATA_W];
  assign head_data = mem[rd_ptr][DATA_W-1:0];

  assign op_unsup  = (op_q == OP_W'(6)) || (op_q == OP_W'(7));

  // The FSM is the only consumer: it pops from IDLE, or straight out of RESP
  // on the handshake so results can stream every second cycle.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = (level != '0);
      RESP:    pop = rsp_valid && rsp_ready && (level != '0);
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_op, cmd_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sh_type   <= '0;
      sh_num    <= '0;
      op_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_op    <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            sh_type <= head_op;
            sh_num  <= head_data;
            op_q    <= head_op;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= op_unsup ? '0 : sh_out;
          rsp_op    <= op_q;
          rsp_err   <= op_unsup;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (pop) begin
              sh_type <= head_op;
              sh_num  <= head_data;
              op_q    <= head_op;
              state   <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/shift_cmd_sequencer.md
Name: shift_cmd_sequencer

Overview:
- Sequential front/back-end wrapped around the team's combinational 8-bit shifter (3-bit op, 8-bit operand, fixed shift amount).
- Buffers incoming shift commands in a small FIFO and issues them one at a time from registered outputs that drive the shifter's op and operand inputs.
- Captures the shifter's result and presents it downstream with a valid/ready handshake, in command order.

Parameters:
- DATA_W, 8, operand/result width; must match the shifter.
- OP_W, 3, shift-op code width.
- DEPTH, 4, command FIFO entries; power of 2, >=2.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  upstream command valid
- cmd_ready  out  1  FIFO can accept a command
- cmd_op  in  OP_W  shift-op code
- cmd_data  in  DATA_W  operand
- sh_type  out  OP_W  registered op to shifter
- sh_num  out  DATA_W  registered operand to shifter
- sh_out  in  DATA_W  shifter result (combinational from sh_type/sh_num)
- rsp_valid  out  1  result valid
- rsp_ready  in  1  downstream accepts result
- rsp_data  out  DATA_W  result
- rsp_op  out  OP_W  op that produced rsp_data
- rsp_err  out  1  op was unsupported (110/111)
- level  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset, asynchronous while rst_n=0:
  - FIFO empty, level=0, FSM=IDLE.
  - sh_type, sh_num, rsp_data, rsp_op, rsp_err, rsp_valid all 0.
  - cmd_ready=1 once reset is released.
- Reset mid-operation discards all queued, in-flight and pending-response commands. No response for them ever appears.
- FIFO:
  - cmd_ready = (level != DEPTH). It is registered-state only, with no combinational path from rsp_ready.
  - Push on cmd_valid & cmd_ready.
  - Pop only by the FSM, as below.
  - When full, a same-cycle pop does not enable a push; cmd_ready stays 0 that cycle.
  - Simultaneous push and pop: level unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
- FSM, states IDLE, EXEC, RESP:
  - IDLE: if level!=0, pop head; load sh_type<=op, sh_num<=data, internal op copy; go EXEC. Otherwise stay.
  - EXEC (one cycle; the shifter settles on the registered inputs):
    - rsp_data <= sh_out, or 0 if op is 110/111.
    - rsp_op <= issued op.
    - rsp_err <= (op==110 or 111).
    - rsp_valid <= 1; go RESP.
  - RESP: hold rsp_* stable while rsp_valid & !rsp_ready. On rsp_valid & rsp_ready:
    - if level!=0: pop the next command into sh_* and go EXEC (back-to-back), rsp_valid <= 0;
    - else: go IDLE, rsp_valid <= 0.
- A push in the same cycle as the RESP handshake, with the FIFO otherwise empty, is not seen until the next cycle; the FSM goes to IDLE first.
- sh_type/sh_num hold their last issued value in IDLE and RESP.
- Latency:
  - Command accepted at edge N into an empty FIFO with the FSM in IDLE: popped at edge N+1, rsp_valid=1 after edge N+2.
  - Peak throughput: one result per 2 cycles.
- Capacity: DEPTH+1 commands outstanding with rsp_ready=0 (DEPTH queued, one in RESP).
- Ordering: responses leave in exactly acceptance order.
- Inputs cmd_op/cmd_data are ignored when cmd_valid=0.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with random inputs -> all outputs 0 immediately, level=0; after release cmd_ready=1, rsp_valid=0.
- Single command (shifter k=3): op=000, data=B5 accepted at edge N, rsp_ready=1 -> sh_type=000, sh_num=B5 after N+1; rsp_valid=1, rsp_data=16, rsp_op=000, rsp_err=0 after N+2; rsp_valid drops next edge.
- Ordered stream: ops 000, 001, 100 on B5, rsp_ready=1 -> rsp_data 16, A8, B6 in order, each rsp_valid pulse 2 cycles apart.
- Full/backpressure: rsp_ready=0, offer 6 back-to-back commands -> exactly 5 accepted, level=4, cmd_ready=0, rsp_data frozen for 10 cycles; then rsp_ready=1 -> all 5 delivered in order, level returns to 0.
- Unsupported op: op=110, data=FF -> rsp_err=1, rsp_data=00, rsp_op=110; the following op=010 command completes normally with rsp_err=0.
- Reset mid-operation: 3 queued and rsp_valid=1 -> pulse rst_n low -> no stale response afterwards; a new command then completes with normal 2-cycle latency.
